// File: rtl/pcie_fc_pkg.sv
// Shared constants for the PCIe flow-control credit monitor: fc_sel bank
// encodings, poll FSM states and credit field widths.
package pcie_fc_pkg;

    localparam logic [2:0] FC_SEL_RX = 3'b010;  // core reports consumed RX credits
    localparam logic [2:0] FC_SEL_TX = 3'b100;  // core reports available TX credits

    localparam int HDR_W   = 8;   // header credit counters
    localparam int DAT_W   = 12;  // data credit counters
    localparam int DCRED_W = 9;   // per-TLP data credit cost

    typedef enum logic {
        S_RX = 1'b0,
        S_TX = 1'b1
    } fc_state_e;

endpackage

// File: rtl/pcie_fc_credit_mon_if.sv
// Bundle between the credit monitor, the PCIe core flow-control port and the
// TX arbiter. master = monitor side, slave = core/arbiter side.
interface pcie_fc_credit_mon_if;
    import pcie_fc_pkg::*;

    logic [DAT_W-1:0]   fc_cpld;
    logic [HDR_W-1:0]   fc_cplh;
    logic [DAT_W-1:0]   fc_npd;
    logic [HDR_W-1:0]   fc_nph;
    logic [DAT_W-1:0]   fc_pd;
    logic [HDR_W-1:0]   fc_ph;
    logic [2:0]         fc_sel;

    logic               tx_cpld_issue;
    logic [DCRED_W-1:0] tx_cpld_dcred;
    logic               tx_mrd_issue;
    logic               tx_mwr_issue;
    logic [DCRED_W-1:0] tx_mwr_dcred;

    logic               tx_cpld_gnt;
    logic               tx_mrd_gnt;
    logic               tx_mwr_gnt;
    logic               fc_sample_vld;

    modport master (
        input  fc_cpld, fc_cplh, fc_npd, fc_nph, fc_pd, fc_ph,
        input  tx_cpld_issue, tx_cpld_dcred, tx_mrd_issue, tx_mwr_issue, tx_mwr_dcred,
        output fc_sel, tx_cpld_gnt, tx_mrd_gnt, tx_mwr_gnt, fc_sample_vld
    );

    modport slave (
        output fc_cpld, fc_cplh, fc_npd, fc_nph, fc_pd, fc_ph,
        output tx_cpld_issue, tx_cpld_dcred, tx_mrd_issue, tx_mwr_issue, tx_mwr_dcred,
        input  fc_sel, tx_cpld_gnt, tx_mrd_gnt, tx_mwr_gnt, fc_sample_vld
    );

endinterface

// File: rtl/pcie_fc_shadow_cnt.sv
// Shadow credit counter: optionally reloads from the core sample, then
// subtracts a debit with saturation at zero. The next-state value is exported
// so grants can be registered from it without an extra cycle of lag.
module pcie_fc_shadow_cnt #(
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_val,
    input  logic              debit,
    input  logic [DATA_W-1:0] debit_amt,
    output logic [DATA_W-1:0] cnt_nxt
);

    logic [DATA_W-1:0] cnt_q;
    logic [DATA_W-1:0] cnt_d;
    logic [DATA_W-1:0] base;

    function automatic logic [DATA_W-1:0] sat_sub(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

    // Reload (when sampling) first, then apply any debit from the same cycle.
    always_comb begin
        base  = load ? load_val : cnt_q;
        cnt_d = debit ? sat_sub(base, debit_amt) : base;
    end

    assign cnt_nxt = cnt_d;

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pcie_fc_credit_mon.sv
// PCIe flow-control credit monitor. Alternately polls the core's RX-consumed
// and TX-available credit banks, keeps locally debited TX shadow counters and
// drives registered CplD / MRd / MWr grants to the TX arbiter.
module pcie_fc_credit_mon
    import pcie_fc_pkg::*;
#(
    parameter int unsigned P_FC_SEL_LAT            = 2,
    parameter int unsigned P_RX_CONSTRAINT_FC_CPLD = 8,
    parameter int unsigned P_RX_CONSTRAINT_FC_CPLH = 8,
    parameter int unsigned P_TX_CONSTRAINT_FC_CPLD = 1,
    parameter int unsigned P_TX_CONSTRAINT_FC_CPLH = 1,
    parameter int unsigned P_TX_CONSTRAINT_FC_NPD  = 1,
    parameter int unsigned P_TX_CONSTRAINT_FC_NPH  = 1,
    parameter int unsigned P_TX_CONSTRAINT_FC_PD   = 32,
    parameter int unsigned P_TX_CONSTRAINT_FC_PH   = 1
) (
    input  logic                    pcie_user_clk,
    input  logic                    pcie_user_rst,
    pcie_fc_credit_mon_if.master    fc_if
);

    localparam int CNT_W = 4;  // dwell counter covers latencies up to 15
    localparam logic [CNT_W-1:0] LAT     = CNT_W'(P_FC_SEL_LAT);
    localparam logic [DAT_W-1:0] RX_CPLD = DAT_W'(P_RX_CONSTRAINT_FC_CPLD);
    localparam logic [HDR_W-1:0] RX_CPLH = HDR_W'(P_RX_CONSTRAINT_FC_CPLH);
    localparam logic [DAT_W-1:0] C_CPLD  = DAT_W'(P_TX_CONSTRAINT_FC_CPLD);
    localparam logic [HDR_W-1:0] C_CPLH  = HDR_W'(P_TX_CONSTRAINT_FC_CPLH);
    localparam logic [DAT_W-1:0] C_NPD   = DAT_W'(P_TX_CONSTRAINT_FC_NPD);
    localparam logic [HDR_W-1:0] C_NPH   = HDR_W'(P_TX_CONSTRAINT_FC_NPH);
    localparam logic [DAT_W-1:0] C_PD    = DAT_W'(P_TX_CONSTRAINT_FC_PD);
    localparam logic [HDR_W-1:0] C_PH    = HDR_W'(P_TX_CONSTRAINT_FC_PH);

    fc_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DAT_W-1:0]   rx_cpld_snap_q, rx_cpld_snap_d;
    logic [HDR_W-1:0]   rx_cplh_snap_q, rx_cplh_snap_d;
    logic               cpld_gnt_q, cpld_gnt_d;
    logic               mrd_gnt_q, mrd_gnt_d;
    logic               mwr_gnt_q, mwr_gnt_d;
    logic               capture, rx_cap, tx_cap;

    logic [DAT_W-1:0]   cpld_nxt, npd_nxt, pd_nxt;
    logic [HDR_W-1:0]   cplh_nxt, nph_nxt, ph_nxt;

    // Data debits are zero-extended to the data credit width.
    logic [DAT_W-1:0]   cpld_debit, mwr_debit;
    assign cpld_debit = {{(DAT_W-DCRED_W){1'b0}}, fc_if.tx_cpld_dcred};
    assign mwr_debit  = {{(DAT_W-DCRED_W){1'b0}}, fc_if.tx_mwr_dcred};

    assign capture = (cnt_q == LAT);
    assign rx_cap  = capture && (state_q == S_RX);
    assign tx_cap  = capture && (state_q == S_TX);

    // Poll FSM: dwell LAT+1 cycles per bank, sampling on the last one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        if (capture) begin
            cnt_d   = '0;
            state_d = (state_q == S_RX) ? S_TX : S_RX;
        end
    end

    // Poll FSM registers.
    always_ff @(posedge pcie_user_clk) begin
        if (pcie_user_rst) begin
            state_q <= S_RX;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    pcie_fc_shadow_cnt #(.DATA_W(DAT_W)) u_cpld (
        .clk(pcie_user_clk), .rst(pcie_user_rst), .load(tx_cap), .load_val(fc_if.fc_cpld),
        .debit(fc_if.tx_cpld_issue), .debit_amt(cpld_debit), .cnt_nxt(cpld_nxt));
    pcie_fc_shadow_cnt #(.DATA_W(HDR_W)) u_cplh (
        .clk(pcie_user_clk), .rst(pcie_user_rst), .load(tx_cap), .load_val(fc_if.fc_cplh),
        .debit(fc_if.tx_cpld_issue), .debit_amt(HDR_W'(1)), .cnt_nxt(cplh_nxt));
    pcie_fc_shadow_cnt #(.DATA_W(DAT_W)) u_npd (
        .clk(pcie_user_clk), .rst(pcie_user_rst), .load(tx_cap), .load_val(fc_if.fc_npd),
        .debit(fc_if.tx_mrd_issue), .debit_amt(DAT_W'(1)), .cnt_nxt(npd_nxt));
    pcie_fc_shadow_cnt #(.DATA_W(HDR_W)) u_nph (
        .clk(pcie_user_clk), .rst(pcie_user_rst), .load(tx_cap), .load_val(fc_if.fc_nph),
        .debit(fc_if.tx_mrd_issue), .debit_amt(HDR_W'(1)), .cnt_nxt(nph_nxt));
    pcie_fc_shadow_cnt #(.DATA_W(DAT_W)) u_pd (
        .clk(pcie_user_clk), .rst(pcie_user_rst), .load(tx_cap), .load_val(fc_if.fc_pd),
        .debit(fc_if.tx_mwr_issue), .debit_amt(mwr_debit), .cnt_nxt(pd_nxt));
    pcie_fc_shadow_cnt #(.DATA_W(HDR_W)) u_ph (
        .clk(pcie_user_clk), .rst(pcie_user_rst), .load(tx_cap), .load_val(fc_if.fc_ph),
        .debit(fc_if.tx_mwr_issue), .debit_amt(HDR_W'(1)), .cnt_nxt(ph_nxt));

    // RX snapshots and grants, evaluated on next-state values so an issue or
    // sample in cycle N shows up in the grants at N+1.
    always_comb begin
        rx_cpld_snap_d = rx_cap ? fc_if.fc_cpld : rx_cpld_snap_q;
        rx_cplh_snap_d = rx_cap ? fc_if.fc_cplh : rx_cplh_snap_q;
        cpld_gnt_d = (cpld_nxt >= C_CPLD) && (cplh_nxt >= C_CPLH);
        mrd_gnt_d  = (npd_nxt >= C_NPD) && (nph_nxt >= C_NPH) &&
                     (rx_cpld_snap_d <= RX_CPLD) && (rx_cplh_snap_d <= RX_CPLH);
        mwr_gnt_d  = (pd_nxt >= C_PD) && (ph_nxt >= C_PH);
    end

    // Snapshot and grant registers.
    always_ff @(posedge pcie_user_clk) begin
        if (pcie_user_rst) begin
            rx_cpld_snap_q <= '0;
            rx_cplh_snap_q <= '0;
            cpld_gnt_q     <= 1'b0;
            mrd_gnt_q      <= 1'b0;
            mwr_gnt_q      <= 1'b0;
        end else begin
            rx_cpld_snap_q <= rx_cpld_snap_d;
            rx_cplh_snap_q <= rx_cplh_snap_d;
            cpld_gnt_q     <= cpld_gnt_d;
            mrd_gnt_q      <= mrd_gnt_d;
            mwr_gnt_q      <= mwr_gnt_d;
        end
    end

    assign fc_if.fc_sel        = (state_q == S_RX) ? FC_SEL_RX : FC_SEL_TX;
    assign fc_if.fc_sample_vld = tx_cap;
    assign fc_if.tx_cpld_gnt   = cpld_gnt_q;
    assign fc_if.tx_mrd_gnt    = mrd_gnt_q;
    assign fc_if.tx_mwr_gnt    = mwr_gnt_q;

endmodule

// File: tb/tb_pcie_fc_credit_mon.sv
// Bench for pcie_fc_credit_mon: a directed vector table, hand-written corner
// sequences and a randomized run, all checked against a phase-based
// reference model of the credit rules.
module tb_pcie_fc_credit_mon;

    localparam int L       = 2;
    localparam int RND     = 2 * (L + 1);
    localparam int RX_CPLD = 8, RX_CPLH = 8;
    localparam int C_CPLD = 1, C_CPLH = 1, C_NPD = 1, C_NPH = 1, C_PD = 32, C_PH = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       cpld_iss, mrd_iss, mwr_iss;
    logic [8:0] cpld_dc, mwr_dc;
    // bank index: 0 cpld, 1 cplh, 2 npd, 3 nph, 4 pd, 5 ph
    int         tx_b[6];
    int         rx_b[6];

    pcie_fc_credit_mon_if fc_if();

    pcie_fc_credit_mon #(.P_FC_SEL_LAT(L)) dut (
        .pcie_user_clk (clk),
        .pcie_user_rst (rst),
        .fc_if         (fc_if)
    );

    // Core model: present the bank selected by fc_sel.
    always_comb begin
        if (fc_if.fc_sel == 3'b100) begin
            fc_if.fc_cpld = 12'(tx_b[0]); fc_if.fc_cplh = 8'(tx_b[1]);
            fc_if.fc_npd  = 12'(tx_b[2]); fc_if.fc_nph  = 8'(tx_b[3]);
            fc_if.fc_pd   = 12'(tx_b[4]); fc_if.fc_ph   = 8'(tx_b[5]);
        end else begin
            fc_if.fc_cpld = 12'(rx_b[0]); fc_if.fc_cplh = 8'(rx_b[1]);
            fc_if.fc_npd  = 12'(rx_b[2]); fc_if.fc_nph  = 8'(rx_b[3]);
            fc_if.fc_pd   = 12'(rx_b[4]); fc_if.fc_ph   = 8'(rx_b[5]);
        end
    end

    assign fc_if.tx_cpld_issue = cpld_iss;
    assign fc_if.tx_cpld_dcred = cpld_dc;
    assign fc_if.tx_mrd_issue  = mrd_iss;
    assign fc_if.tx_mwr_issue  = mwr_iss;
    assign fc_if.tx_mwr_dcred  = mwr_dc;

    int nchk = 0;
    int nerr = 0;

    // Reference model state: cycles since reset, shadows, RX snapshots, grants.
    int m_ph;
    int m_sh[6];
    int m_rxd, m_rxh;
    bit m_g_cpld, m_g_mrd, m_g_mwr;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input bit exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v < 0) ? 0 : v;
    endfunction

    task automatic model_step();
        int p;
        if (rst) begin
            m_ph = 0;
            foreach (m_sh[i]) m_sh[i] = 0;
            m_rxd = 0; m_rxh = 0;
            m_g_cpld = 0; m_g_mrd = 0; m_g_mwr = 0;
            chk_en = 1'b1;
            return;
        end
        p = m_ph % RND;
        if (p == L) begin
            m_rxd = rx_b[0]; m_rxh = rx_b[1];
        end
        if (p == RND - 1) begin
            foreach (m_sh[i]) m_sh[i] = tx_b[i];
        end
        if (cpld_iss) begin m_sh[0] = sat(m_sh[0] - int'(cpld_dc)); m_sh[1] = sat(m_sh[1] - 1); end
        if (mrd_iss)  begin m_sh[2] = sat(m_sh[2] - 1);             m_sh[3] = sat(m_sh[3] - 1); end
        if (mwr_iss)  begin m_sh[4] = sat(m_sh[4] - int'(mwr_dc));  m_sh[5] = sat(m_sh[5] - 1); end
        m_g_cpld = (m_sh[0] >= C_CPLD) && (m_sh[1] >= C_CPLH);
        m_g_mrd  = (m_sh[2] >= C_NPD) && (m_sh[3] >= C_NPH) && (m_rxd <= RX_CPLD) && (m_rxh <= RX_CPLH);
        m_g_mwr  = (m_sh[4] >= C_PD) && (m_sh[5] >= C_PH);
        m_ph++;
    endtask

    // One clock: compare outputs against the model, advance model and DUT.
    task automatic tick();
        int p;
        #1;
        if (chk_en) begin
            p = m_ph % RND;
            chk("m_fc_sel", int'(fc_if.fc_sel), (p < L + 1) ? 2 : 4);
            chk_bit("m_sample_vld", fc_if.fc_sample_vld, p == RND - 1);
            chk_bit("m_cpld_gnt", fc_if.tx_cpld_gnt, m_g_cpld);
            chk_bit("m_mrd_gnt", fc_if.tx_mrd_gnt, m_g_mrd);
            chk_bit("m_mwr_gnt", fc_if.tx_mwr_gnt, m_g_mwr);
        end
        model_step();
        @(posedge clk);
        #1;
        cpld_iss = 1'b0; mrd_iss = 1'b0; mwr_iss = 1'b0;
    endtask

    task automatic run_to_phase(input int target);
        for (int k = 0; k <= RND; k++) begin
            if (m_ph % RND == target) return;
            tick();
        end
        chk("run_to_phase", m_ph % RND, target);
    endtask

    typedef struct {
        int       pd;
        bit       mwr;
        int       dcred;
        bit [2:0] sel;
        bit       vld;
        bit       gnt;
    } vec_t;

    vec_t vecs[19];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cpld_iss = 0; mrd_iss = 0; mwr_iss = 0; cpld_dc = 0; mwr_dc = 0;
        foreach (tx_b[i]) begin tx_b[i] = 0; rx_b[i] = 0; end

        // Directed table: pd 64 -> 40 -> debit 16 -> 64; ph held at 4.
        for (int i = 0; i < 19; i++) begin
            vecs[i].pd    = (i < 6) ? 64 : (i < 12) ? 40 : 64;
            vecs[i].mwr   = (i == 12);
            vecs[i].dcred = (i == 12) ? 16 : 0;
            vecs[i].sel   = ((i % 6) < 3) ? 3'b010 : 3'b100;
            vecs[i].vld   = ((i % 6) == 5);
            vecs[i].gnt   = (i >= 6 && i <= 12) || (i == 18);
        end

        @(posedge clk); #1;
        tick(); tick();
        rst = 1'b0;
        tx_b[5] = 4; rx_b[5] = 4;
        for (int i = 0; i < 19; i++) begin
            tx_b[4] = vecs[i].pd; rx_b[4] = vecs[i].pd;
            mwr_iss = vecs[i].mwr; mwr_dc = 9'(vecs[i].dcred);
            #1;
            chk("t_fc_sel", int'(fc_if.fc_sel), int'(vecs[i].sel));
            chk_bit("t_sample_vld", fc_if.fc_sample_vld, vecs[i].vld);
            chk_bit("t_mwr_gnt", fc_if.tx_mwr_gnt, vecs[i].gnt);
            tick();
        end
        foreach (tx_b[i]) begin tx_b[i] = 0; rx_b[i] = 0; end

        // CplD data shadow saturates at zero rather than wrapping.
        tx_b[0] = 5; tx_b[1] = 4;
        run_to_phase(RND - 1); tick();
        chk_bit("cpld_pre", fc_if.tx_cpld_gnt, 1'b1);
        cpld_iss = 1'b1; cpld_dc = 9'd9; tick();
        chk_bit("cpld_sat", fc_if.tx_cpld_gnt, 1'b0);

        // CplH shadow decrements by one per CplD.
        tx_b[0] = 100; tx_b[1] = 2;
        run_to_phase(RND - 1); tick();
        cpld_iss = 1'b1; cpld_dc = 9'd9; tick();
        chk_bit("cplh_one_left", fc_if.tx_cpld_gnt, 1'b1);
        cpld_iss = 1'b1; cpld_dc = 9'd9; tick();
        chk_bit("cplh_zero", fc_if.tx_cpld_gnt, 1'b0);

        // RX consumed CplD over the limit blocks MRd; at the limit allows it.
        tx_b[2] = 100; tx_b[3] = 10; rx_b[0] = 9; rx_b[1] = 0;
        run_to_phase(L); tick();
        run_to_phase(RND - 1); tick();
        chk_bit("mrd_rx9", fc_if.tx_mrd_gnt, 1'b0);
        rx_b[0] = 8;
        run_to_phase(L); tick();
        chk_bit("mrd_rx8", fc_if.tx_mrd_gnt, 1'b1);

        // MRd issued in the TX sample cycle is debited from the fresh sample.
        tx_b[3] = 1;
        run_to_phase(RND - 1);
        mrd_iss = 1'b1; tick();
        chk_bit("mrd_cap_debit", fc_if.tx_mrd_gnt, 1'b0);

        // Reset in the middle of the TX dwell.
        tx_b[0] = 50; tx_b[1] = 5; tx_b[2] = 50; tx_b[3] = 5; tx_b[4] = 64; tx_b[5] = 5;
        rx_b[0] = 0; rx_b[1] = 0;
        run_to_phase(RND - 1); tick();
        run_to_phase(L + 2);
        chk_bit("pre_rst_mwr", fc_if.tx_mwr_gnt, 1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_fc_sel", int'(fc_if.fc_sel), 2);
        chk_bit("rst_cpld_gnt", fc_if.tx_cpld_gnt, 1'b0);
        chk_bit("rst_mrd_gnt", fc_if.tx_mrd_gnt, 1'b0);
        chk_bit("rst_mwr_gnt", fc_if.tx_mwr_gnt, 1'b0);
        chk_bit("rst_vld", fc_if.fc_sample_vld, 1'b0);
        for (int k = 0; k < 2 * RND; k++) tick();

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(7) == 0) begin
                tx_b[0] = $urandom_range(40); tx_b[1] = $urandom_range(3);
                tx_b[2] = $urandom_range(3);  tx_b[3] = $urandom_range(3);
                tx_b[4] = $urandom_range(80); tx_b[5] = $urandom_range(3);
                rx_b[0] = $urandom_range(12); rx_b[1] = $urandom_range(12);
            end
            cpld_iss = ($urandom_range(3) == 0);
            mrd_iss  = ($urandom_range(3) == 0);
            mwr_iss  = ($urandom_range(3) == 0);
            cpld_dc  = ($urandom_range(15) == 0) ? 9'($urandom_range(511)) : 9'($urandom_range(40));
            mwr_dc   = ($urandom_range(15) == 0) ? 9'($urandom_range(511)) : 9'($urandom_range(40));
            rst      = ($urandom_range(149) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
